jk_drive_sequencer: RTL and testbench

Command sequencer sitting directly upstream of the JK flip-flop stage. It accepts buffered {j,k} operations with a repeat count over a valid/ready handshake, drives the flip-flop's j/k inputs one operation per clock, and (optionally) checks the flip-flop's q against an internal reference model. It replaces hand-written per-cycle drive tasks with a reusable, self-checking stimulus stage.

---
 rtl/jk_drive_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_jk_drive_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_drive_sequencer.sv
// jk_drive_sequencer
// Buffers {j,k} operations with a repeat count, then replays them onto a
// downstream JK flip-flop one operation per clock with no bubbles between
// back-to-back commands. j/k, in_ready and busy all come straight from flops.
//
// Optional feature macro: JK_SEQ_CHECK_EN
//   defined   -> a reference model of the flip-flop tracks the expected q.
//                A two-stage check pipeline compares q_obs against it and
//                drives the sticky err flag and the saturating err_cnt.
//                clr_err clears both.
//   undefined -> err/err_cnt are tied to zero, and q_obs/clr_err are ignored.
//                Sequencing behaviour is identical in both builds.

module jk_drive_sequencer #(
  parameter int DEPTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_jk,
  input  logic [REP_W-1:0] in_rep,
  output logic             j,
  output logic             k,
  input  logic             q_obs,
  output logic             busy,
  input  logic             clr_err,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = REP_W + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       op;            // operation on j/k; 00 whenever idle
  logic [1:0]       op_next;
  logic [REP_W-1:0] rep_cnt;       // remaining extra cycles of current op
  logic [REP_W-1:0] rep_cnt_next;

  logic [EW-1:0]    fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_cnt;
  logic [CW-1:0]    fifo_cnt_next;
  logic [EW-1:0]    head;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic             in_ready_r;
  logic             busy_r;

  assign fifo_empty = (fifo_cnt == {CW{1'b0}});
  assign push       = in_valid && in_ready_r;
  assign head       = fifo_mem[rd_ptr];

  // Command storage: write the accepted {jk,rep} at the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_jk, in_rep};
    end
  end

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    fifo_cnt_next = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt + CW'(1);
      2'b01:   fifo_cnt_next = fifo_cnt - CW'(1);
      default: fifo_cnt_next = fifo_cnt;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= {AW{1'b0}};
      rd_ptr   <= {AW{1'b0}};
      fifo_cnt <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_cnt <= fifo_cnt_next;
    end
  end

  // Next state, next drive and pop decision. The head is only visible once it
  // is in the FIFO, so a push into an empty FIFO is popped at the next edge.
  always_comb begin
    state_next   = state;
    op_next      = op;
    rep_cnt_next = rep_cnt;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          op_next      = head[EW-1:REP_W];
          rep_cnt_next = head[REP_W-1:0];
          state_next   = APPLY;
        end else begin
          op_next      = 2'b00;
        end
      end
      APPLY: begin
        if (rep_cnt != {REP_W{1'b0}}) begin
          rep_cnt_next = rep_cnt - REP_W'(1);
        end else if (!fifo_empty) begin
          // Chain straight into the next command: no idle cycle between ops.
          pop          = 1'b1;
          op_next      = head[EW-1:REP_W];
          rep_cnt_next = head[REP_W-1:0];
        end else begin
          op_next      = 2'b00;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        op_next      = 2'b00;
        rep_cnt_next = {REP_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, drive register and registered handshake/status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op         <= 2'b00;
      rep_cnt    <= {REP_W{1'b0}};
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state      <= state_next;
      op         <= op_next;
      rep_cnt    <= rep_cnt_next;
      in_ready_r <= (fifo_cnt_next != FULL_CNT);
      busy_r     <= (fifo_cnt_next != {CW{1'b0}}) || (state_next == APPLY);
    end
  end

  assign j        = op[1];
  assign k        = op[0];
  assign in_ready = in_ready_r;
  assign busy     = busy_r;

`ifdef JK_SEQ_CHECK_EN
  logic       exp_q;       // model of flip-flop q after the last applied op
  logic       exp_known;   // model has seen a set or reset since reset
  logic       chk_vld;     // an op was applied last edge; q_obs valid to check
  logic       err_r;
  logic [7:0] err_cnt_r;
  logic       mismatch;

  // Reference model: mirror what the flip-flop captures from the op on j/k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= 1'b0;
      exp_known <= 1'b0;
      chk_vld   <= 1'b0;
    end else begin
      chk_vld <= (state == APPLY);
      if (state == APPLY) begin
        case (op)
          2'b01: begin
            exp_q     <= 1'b0;
            exp_known <= 1'b1;
          end
          2'b10: begin
            exp_q     <= 1'b1;
            exp_known <= 1'b1;
          end
          2'b11:   exp_q <= ~exp_q;
          default: exp_q <= exp_q;
        endcase
      end
    end
  end

  // Toggles/holds from an unknown start are not checked.
  assign mismatch = chk_vld && exp_known && (q_obs != exp_q);

  // Sticky error flag and saturating counter; a clear wins over a mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r     <= 1'b0;
      err_cnt_r <= 8'h00;
    end else if (clr_err) begin
      err_r     <= 1'b0;
      err_cnt_r <= 8'h00;
    end else if (mismatch) begin
      err_r <= 1'b1;
      if (err_cnt_r != 8'hFF) begin
        err_cnt_r <= err_cnt_r + 8'h01;
      end
    end
  end

  assign err     = err_r;
  assign err_cnt = err_cnt_r;
`else
  logic unused_chk_inputs;

  assign unused_chk_inputs = q_obs ^ clr_err;
  assign err               = 1'b0;
  assign err_cnt           = 8'h00;
`endif

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Self-checking bench for jk_drive_sequencer: a behavioural JK flip-flop
// closes the loop on j/k, and a per-cycle scoreboard expands each accepted
// command into rep+1 expected drive slots.

module tb_jk_drive_sequencer;

  localparam int DEPTH = 4;
  localparam int REP_W = 4;
`ifdef JK_SEQ_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0] jk;
    logic       fst;
  } slot_t;

  typedef struct {
    logic [1:0] jk;
    logic [3:0] rep;
  } cmd_t;

  typedef struct {
    logic [1:0] jk;
    logic       q;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_jk;
  logic [REP_W-1:0] in_rep;
  logic             j;
  logic             k;
  logic             q_obs;
  logic             busy;
  logic             clr_err;
  logic             err;
  logic [7:0]       err_cnt;

  logic q_ff;
  logic ff_load;
  logic ff_val;
  logic fault;

  int n_chk;
  int n_fail;
  bit mon_en;
  int mdl_cnt;
  slot_t pend[$];
  logic [1:0] log_jk[$];
  logic log_q[$];

  jk_drive_sequencer #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_jk(in_jk), .in_rep(in_rep), .j(j), .k(k), .q_obs(q_obs),
    .busy(busy), .clr_err(clr_err), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural JK flip-flop driven by the sequencer.
  always @(posedge clk) begin
    if (ff_load) q_ff <= ff_val;
    else begin
      case ({j, k})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end

  assign q_obs = fault ? 1'b0 : q_ff;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each negedge retires one expected slot for the edge just past
  // and then queues the rep+1 slots of a command accepted at that edge.
  task automatic monitor();
    bit         acc;
    bit         pv;
    bit         vld;
    logic [1:0] acc_jk;
    logic [3:0] acc_rep;
    logic [1:0] ejk;
    slot_t      s;
    acc = 1'b0;
    pv  = 1'b0;
    acc_jk = 2'b00;
    acc_rep = 4'd0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pend.delete();
        mdl_cnt = 0;
        acc = 1'b0;
        pv  = 1'b0;
      end else begin
        if (pend.size() > 0) begin
          s = pend.pop_front();
          ejk = s.jk;
          vld = 1'b1;
          if (s.fst) mdl_cnt--;
        end else begin
          ejk = 2'b00;
          vld = 1'b0;
        end
        if (acc) begin
          for (int r = 0; r <= int'(acc_rep); r++) begin
            s.jk  = acc_jk;
            s.fst = (r == 0);
            pend.push_back(s);
          end
          mdl_cnt++;
        end
        chk("jk_drive", {j, k}, ejk);
        chk("busy", busy, (vld || pend.size() > 0));
        chk("in_ready", in_ready, (mdl_cnt < DEPTH));
        if (pv) log_q.push_back(q_obs);
        if (vld) log_jk.push_back({j, k});
        pv = vld;
        acc = in_valid && in_ready;
        acc_jk = in_jk;
        acc_rep = in_rep;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_cmd(input logic [1:0] jk, input logic [3:0] rep, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_jk = jk;
    in_rep = rep;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("push_timeout", ok, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && pend.size() == 0) done = 1'b1;
    end
    chk("drain_timeout", done, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_err_flag", err, 0);
    chk("clr_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    in_valid = 1'b0;
    clr_err = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic load_ff(input logic v);
    ff_load = 1'b1;
    ff_val = v;
    @(posedge clk);
    #1;
    ff_load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t seq_cmd[4];
    vec_t seq_exp[5];
    cmd_t fill_cmd[6];
    int   s_jk;
    int   s_q;
    int   w;

    seq_cmd[0] = '{2'b10, 4'd0};
    seq_cmd[1] = '{2'b00, 4'd1};
    seq_cmd[2] = '{2'b11, 4'd0};
    seq_cmd[3] = '{2'b01, 4'd0};
    seq_exp[0] = '{2'b10, 1'b1};
    seq_exp[1] = '{2'b00, 1'b1};
    seq_exp[2] = '{2'b00, 1'b1};
    seq_exp[3] = '{2'b11, 1'b0};
    seq_exp[4] = '{2'b01, 1'b0};
    fill_cmd[0] = '{2'b10, 4'd15};
    fill_cmd[1] = '{2'b11, 4'd0};
    fill_cmd[2] = '{2'b01, 4'd1};
    fill_cmd[3] = '{2'b10, 4'd2};
    fill_cmd[4] = '{2'b00, 4'd0};
    fill_cmd[5] = '{2'b11, 4'd1};

    n_chk = 0;
    n_fail = 0;
    mdl_cnt = 0;
    clk = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_jk = 2'b00;
    in_rep = 4'd0;
    clr_err = 1'b0;
    fault = 1'b0;
    ff_load = 1'b1;
    ff_val = 1'b0;
    mon_en = 1'b0;
    fork
      monitor();
    join_none

    // Reset values.
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ff_load = 1'b0;
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Basic sequence against a correct flip-flop, compared against a table.
    s_jk = log_jk.size();
    s_q = log_q.size();
    foreach (seq_cmd[i]) push_cmd(seq_cmd[i].jk, seq_cmd[i].rep, w);
    wait_idle(100);
    chk("seq_len", log_jk.size() - s_jk, 5);
    for (int i = 0; i < 5; i++) begin
      chk("seq_jk", log_jk[s_jk + i], seq_exp[i].jk);
      chk("seq_q", log_q[s_q + i], seq_exp[i].q);
    end
    chk("seq_err", err, 0);

    // Fill: a rep=15 head stalls; 4 more fill the FIFO, the 5th is held.
    for (int i = 0; i < 5; i++) push_cmd(fill_cmd[i].jk, fill_cmd[i].rep, w);
    chk("fill_ready_low", in_ready, 0);
    push_cmd(fill_cmd[5].jk, fill_cmd[5].rep, w);
    chk("fill_fifth_held", (w > 0), 1);
    wait_idle(200);
    chk("fill_err", err, 0);

    // Asynchronous reset in the middle of an APPLY with 3 entries queued.
    push_cmd(2'b11, 4'd15, w);
    for (int i = 0; i < 3; i++) push_cmd(2'b10, 4'd0, w);
    chk("pre_rst_busy", busy, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_j", j, 0);
    chk("mid_rst_k", k, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_err_cnt", err_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Unknown start: toggles before the first set are not checked.
    for (int v = 0; v < 2; v++) begin
      if (v == 1) do_reset();
      load_ff(v[0]);
      push_cmd(2'b11, 4'd2, w);
      push_cmd(2'b10, 4'd0, w);
      wait_idle(100);
      chk("unk_err", err, 0);
      chk("unk_err_cnt", err_cnt, 0);
    end

    // Fault: q stuck low during a 4-cycle set.
    clr_pulse();
    fault = 1'b1;
    push_cmd(2'b10, 4'd3, w);
    wait_idle(100);
    fault = 1'b0;
    chk("fault_err", err, CHK_EN ? 1 : 0);
    chk("fault_err_cnt", err_cnt, CHK_EN ? 4 : 0);
    clr_pulse();

    // Saturation: >255 mismatches, with a clear part-way through.
    fault = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_cmd(2'b10, 4'd15, w);
      if (i == 6) clr_pulse();
    end
    wait_idle(400);
    fault = 1'b0;
    chk("sat_err", err, CHK_EN ? 1 : 0);
    chk("sat_err_cnt", err_cnt, CHK_EN ? 255 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
